// File: rtl/cache_axi_rd_arb_pkg.sv
// Shared types and constants for the I/D cache AXI read arbiter.
package cache_axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [3:0] ARB_ID_I       = 4'd0;
    localparam logic [3:0] ARB_ID_D       = 4'd1;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/cache_axi_rd_arb_pick2.sv
// Two-way grant decision. CACHE_ARB_RR_EN selects round-robin (with a
// last_grant register); otherwise the D-cache has fixed priority.
module arb_pick2 (
`ifdef CACHE_ARB_RR_EN
    input  logic clk,
    input  logic resetn,
    input  logic grant_en,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic any_req,
    output logic pick_d
);

    assign any_req = i_req | d_req;

`ifdef CACHE_ARB_RR_EN
    // 0 = I-cache was granted last, 1 = D-cache
    logic last_grant;

    assign pick_d = d_req & (~i_req | ~last_grant);

    always_ff @(posedge clk) begin
        if (!resetn)
            last_grant <= 1'b0;
        else if (grant_en)
            last_grant <= pick_d;
    end
`else
    assign pick_d = d_req;
`endif

endmodule

// File: rtl/cache_axi_rd_arb.sv
// I/D cache miss read arbiter onto a single AXI read port, one burst in flight.
// Arbitration policy is chosen by CACHE_ARB_RR_EN (see arb_pick2).
module cache_axi_rd_arb
    import cache_axi_rd_arb_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_rd_req,
    input  logic [31:0] i_rd_addr,
    input  logic [3:0]  i_rd_len,
    output logic        i_rd_ack,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    input  logic        d_rd_req,
    input  logic [31:0] d_rd_addr,
    input  logic [3:0]  d_rd_len,
    output logic        d_rd_ack,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] ret_data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    arb_state_e state, state_nx;
    logic       any_req, pick_d, grant, beat, owner_d;

    // Only one burst is ever outstanding, so the R channel ID is not needed.
    logic unused_rid;
    assign unused_rid = ^rid;

    arb_pick2 u_pick (
`ifdef CACHE_ARB_RR_EN
        .clk      (clk),
        .resetn   (resetn),
        .grant_en (grant),
`endif
        .i_req    (i_rd_req),
        .d_req    (d_rd_req),
        .any_req  (any_req),
        .pick_d   (pick_d)
    );

    assign grant = (state == ST_IDLE) && any_req && resetn;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (any_req)         state_nx = ST_ADDR;
            ST_ADDR: if (arready)         state_nx = ST_DATA;
            ST_DATA: if (rvalid && rlast) state_nx = ST_IDLE;
            default:                      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            arid   <= 4'd0;
            araddr <= 32'd0;
            arlen  <= 8'd0;
        end else begin
            state <= state_nx;
            if (grant) begin
                arid   <= pick_d ? ARB_ID_D : ARB_ID_I;
                araddr <= pick_d ? d_rd_addr : i_rd_addr;
                arlen  <= {4'b0, (pick_d ? d_rd_len : i_rd_len)};
            end
        end
    end

    assign i_rd_ack = grant & ~pick_d;
    assign d_rd_ack = grant &  pick_d;

    assign arvalid = (state == ST_ADDR);
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;

    // The latched ID doubles as the owner of the burst in flight.
    assign owner_d = (arid == ARB_ID_D);
    assign rready  = (state == ST_DATA);
    assign beat    = rready & rvalid;

    assign i_ret_valid = beat & ~owner_d;
    assign i_ret_last  = beat & ~owner_d & rlast;
    assign d_ret_valid = beat &  owner_d;
    assign d_ret_last  = beat &  owner_d & rlast;
    assign ret_data    = rdata;

endmodule

// File: tb/tb_cache_axi_rd_arb.sv
// Self-checking bench for cache_axi_rd_arb against a transaction-level model.
module tb_cache_axi_rd_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_rd_req, d_rd_req;
    logic [31:0] i_rd_addr, d_rd_addr;
    logic [3:0]  i_rd_len, d_rd_len;
    logic        i_rd_ack, d_rd_ack;
    logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
    logic [31:0] ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready;

    cache_axi_rd_arb dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len), .i_rd_ack(i_rd_ack),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_len(d_rd_len), .d_rd_ack(d_rd_ack),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .ret_data(ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: who was granted last (0 = I) and the expected AR fields.
    bit          mlast;
    bit [3:0]    exp_id;
    bit [31:0]   exp_addr;
    bit [3:0]    exp_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_i_ret"}, i_ret_valid, 0);
        chk({tag, "_d_ret"}, d_ret_valid, 0);
        chk({tag, "_i_last"}, i_ret_last, 0);
        chk({tag, "_d_last"}, d_ret_last, 0);
    endtask

    task automatic chk_ar(input string tag);
        chk({tag, "_arvalid"}, arvalid, 1);
        chk({tag, "_araddr"},  araddr, exp_addr);
        chk({tag, "_arlen"},   arlen, {28'd0, exp_len});
        chk({tag, "_arid"},    arid, exp_id);
        chk({tag, "_arsize"},  arsize, 3'b010);
        chk({tag, "_arburst"}, arburst, 2'b01);
        chk({tag, "_rready"},  rready, 0);
    endtask

    // Applies reset for two cycles; requests held high to confirm acks are masked.
    task automatic do_reset();
        resetn = 1'b0;
        d_rd_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_i_ack", i_rd_ack, 0);
        chk("rst_d_ack", d_rd_ack, 0);
        chk("rst_arid", arid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk_quiet("rst");
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        resetn   = 1'b1;
        mlast    = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge in IDLE with requests already driven.
    task automatic do_grant(output bit pd);
        #1;
`ifdef CACHE_ARB_RR_EN
        pd = d_rd_req && (!i_rd_req || !mlast);
`else
        pd = d_rd_req;
`endif
        chk("d_ack", d_rd_ack, pd);
        chk("i_ack", i_rd_ack, !pd);
        mlast    = pd;
        exp_id   = pd ? 4'd1 : 4'd0;
        exp_addr = pd ? d_rd_addr : i_rd_addr;
        exp_len  = pd ? d_rd_len : i_rd_len;
        @(negedge clk);
        if (pd) d_rd_req = 1'b0; else i_rd_req = 1'b0;
    endtask

    task automatic addr_phase(input int stall);
        arready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            #1;
            chk_ar("ar_stall");
            chk("ar_no_iack", i_rd_ack, 0);
            chk("ar_no_dack", d_rd_ack, 0);
            @(negedge clk);
        end
        arready = 1'b1;
        #1;
        chk_ar("ar_hs");
        @(negedge clk);
        arready = 1'b0;
    endtask

    task automatic data_phase(input int nbeats, input bit pd, input bit gaps);
        bit last;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                rvalid = 1'b0;
                rlast  = $urandom_range(0, 1);
                #1;
                chk("gap_rready", rready, 1);
                chk_quiet("gap");
                @(negedge clk);
            end
            last   = (b == nbeats - 1);
            rvalid = 1'b1;
            rlast  = last;
            rdata  = $urandom;
            rid    = $urandom_range(0, 15);
            #1;
            chk("beat_rready", rready, 1);
            chk("beat_d_valid", d_ret_valid, pd);
            chk("beat_i_valid", i_ret_valid, !pd);
            chk("beat_d_last", d_ret_last, pd && last);
            chk("beat_i_last", i_ret_last, !pd && last);
            chk("beat_data", ret_data, rdata);
            @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk("post_rready", rready, 0);
        chk("post_arvalid", arvalid, 0);
    endtask

    bit pd;
    bit exp_order [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        i_rd_req = 0; d_rd_req = 0;
        i_rd_addr = 0; d_rd_addr = 0; i_rd_len = 0; d_rd_len = 0;
        arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
        mlast = 0;
        @(negedge clk);
        do_reset();

        // D-only burst, arready one cycle after arvalid.
        d_rd_req = 1; d_rd_addr = 32'h1FC0_0040; d_rd_len = 4'd7;
        do_grant(pd);
        chk("s1_pick_d", pd, 1);
        addr_phase(1);
        data_phase(8, 1'b1, 1'b0);

        // Simultaneous requests: winner served, loser acked in the next IDLE cycle.
        i_rd_req = 1; i_rd_addr = 32'h0000_1000; i_rd_len = 4'd3;
        d_rd_req = 1; d_rd_addr = 32'h0000_2000; d_rd_len = 4'd1;
        do_grant(pd);
        addr_phase(0);
        data_phase(d_rd_len + 1, pd, 1'b0);
        do_grant(pd);
        chk("s2_second_is_i", pd, 0);
        addr_phase(0);
        data_phase(i_rd_len + 1, pd, 1'b0);

        // Three back-to-back contended rounds from reset.
        do_reset();
`ifdef CACHE_ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b1, 1'b1, 1'b1};
`endif
        for (int r = 0; r < 3; r++) begin
            i_rd_req = 1; i_rd_addr = 32'h100 * (r + 1);        i_rd_len = 4'(r);
            d_rd_req = 1; d_rd_addr = 32'h8000 + 32'h40 * r;    d_rd_len = 4'(r + 1);
            do_grant(pd);
            chk("s3_order", pd, exp_order[r]);
            addr_phase(0);
            data_phase(32'(exp_len) + 1, pd, 1'b0);
        end
        i_rd_req = 0; d_rd_req = 0;
        @(negedge clk);

        // AR stalled for five cycles.
        i_rd_req = 1; i_rd_addr = 32'hABCD_0010; i_rd_len = 4'd15;
        do_grant(pd);
        addr_phase(5);
        data_phase(16, pd, 1'b1);

        // Reset arriving on beat 3 of 8 abandons the burst.
        d_rd_req = 1; d_rd_addr = 32'h0040_0000; d_rd_len = 4'd7;
        do_grant(pd);
        addr_phase(0);
        for (int b = 0; b < 8; b++) begin
            resetn = (b != 2);
            rvalid = 1'b1;
            rlast  = (b == 7);
            rdata  = $urandom;
            #1;
            if (b < 2) begin
                chk("rst_mid_beat", d_ret_valid, 1);
            end else if (b > 2) begin
                chk("rst_mid_rready", rready, 0);
                chk("rst_mid_arvalid", arvalid, 0);
                chk_quiet("rst_mid");
            end
            @(negedge clk);
        end
        rvalid = 0; rlast = 0;
        mlast = 0;

        // Stray R beats while idle.
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1;
            rlast  = $urandom_range(0, 1);
            rdata  = $urandom;
            #1;
            chk("stray_rready", rready, 0);
            chk_quiet("stray");
            @(negedge clk);
        end
        rvalid = 0; rlast = 0;

        // Randomized traffic against the model.
        for (int t = 0; t < 12; t++) begin
            i_rd_req  = $urandom_range(0, 1);
            d_rd_req  = i_rd_req ? 1'($urandom_range(0, 1)) : 1'b1;
            i_rd_addr = $urandom & 32'hFFFF_FFFC;
            d_rd_addr = $urandom & 32'hFFFF_FFFC;
            i_rd_len  = 4'($urandom_range(0, 15));
            d_rd_len  = 4'($urandom_range(0, 15));
            do_grant(pd);
            addr_phase($urandom_range(0, 3));
            data_phase(32'(exp_len) + 1, pd, 1'b1);
            i_rd_req = 0; d_rd_req = 0;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
